edge_wave_gen: RTL



---
 rtl/edge_gen_pkg.sv | 19 +
 rtl/edge_wave_gen_if.sv | 21 ++
 rtl/edge_len_counter.sv | 29 ++
 rtl/edge_wave_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/edge_gen_pkg.sv
// Shared types and default widths for the programmable edge/pulse-train generator.
package edge_gen_pkg;

  localparam int EDGE_LEN_W = 8;
  localparam int EDGE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } edge_gen_state_e;

  typedef struct packed {
    logic [EDGE_LEN_W-1:0] high;
    logic [EDGE_LEN_W-1:0] low;
    logic [EDGE_CNT_W-1:0] count;
  } edge_cmd_t;

endpackage

// File: rtl/edge_wave_gen_if.sv
// Command handshake bundle: the master issues a waveform command, the generator accepts it when ready.
interface edge_wave_gen_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_high_i;
  logic [LEN_W-1:0] cmd_low_i;
  logic [CNT_W-1:0] cmd_count_i;

  modport master (
    output cmd_valid_i, cmd_high_i, cmd_low_i, cmd_count_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_high_i, cmd_low_i, cmd_count_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/edge_len_counter.sv
// Loadable down-counter with a zero flag; times one high or low phase.
module edge_len_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/edge_wave_gen.sv
// Turns a (high, low, count) command into a registered serial waveform with
// cycle-aligned rising/falling markers, a busy flag and a completion pulse.
module edge_wave_gen
  import edge_gen_pkg::*;
#(
  parameter int LEN_W = EDGE_LEN_W,
  parameter int CNT_W = EDGE_CNT_W
) (
  input  logic            clk,
  input  logic            rstn,
  edge_wave_gen_if.slave  cmd,
  input  logic            abort_i,
  output logic            a_o,
  output logic            rising_edge_o,
  output logic            falling_edge_o,
  output logic            busy_o,
  output logic            done_o
);

  edge_gen_state_e  state_reg;
  logic [LEN_W-1:0] h_reg;
  logic [LEN_W-1:0] l_reg;
  logic [CNT_W-1:0] period_reg;
  logic             a_reg, rise_reg, fall_reg, busy_reg, done_reg;

  logic             handshake;
  logic [LEN_W-1:0] cmd_h, cmd_l;
  logic             last_period;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic [LEN_W-1:0] cnt_load_val, cnt_val;

  // Zero-length phases are stretched to one cycle so every period is visible.
  assign cmd_h       = (cmd.cmd_high_i == '0) ? LEN_W'(1) : cmd.cmd_high_i;
  assign cmd_l       = (cmd.cmd_low_i  == '0) ? LEN_W'(1) : cmd.cmd_low_i;
  assign handshake   = (state_reg == IDLE) && cmd.cmd_valid_i;
  assign last_period = (period_reg == CNT_W'(1));
  assign cnt_one     = (cnt_val == LEN_W'(1));

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (handshake && (cmd.cmd_count_i != '0)) begin
          cnt_load     = 1'b1;
          cnt_load_val = cmd_h - LEN_W'(1);
        end
      end
      HIGH: begin
        if (!abort_i) begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = l_reg - LEN_W'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      LOW: begin
        if (!abort_i) begin
          if (cnt_zero) begin
            cnt_load     = !last_period;
            cnt_load_val = h_reg - LEN_W'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  edge_len_counter #(.W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      h_reg      <= '0;
      l_reg      <= '0;
      period_reg <= '0;
      a_reg      <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            h_reg      <= cmd_h;
            l_reg      <= cmd_l;
            period_reg <= cmd.cmd_count_i;
            if (cmd.cmd_count_i == '0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= HIGH;
              a_reg     <= 1'b1;
              rise_reg  <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (abort_i) begin
            state_reg <= IDLE;
            a_reg     <= 1'b0;
            fall_reg  <= a_reg;
            busy_reg  <= 1'b0;
          end else if (cnt_zero) begin
            state_reg <= LOW;
            a_reg     <= 1'b0;
            fall_reg  <= 1'b1;
            // A one-cycle low phase makes its first cycle also the last one.
            done_reg  <= last_period && (l_reg == LEN_W'(1));
          end
        end
        LOW: begin
          if (abort_i) begin
            state_reg <= IDLE;
            a_reg     <= 1'b0;
            fall_reg  <= a_reg;
            busy_reg  <= 1'b0;
          end else if (cnt_zero) begin
            period_reg <= period_reg - CNT_W'(1);
            if (last_period) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= HIGH;
              a_reg     <= 1'b1;
              rise_reg  <= 1'b1;
            end
          end else begin
            done_reg <= last_period && cnt_one;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready_o = (state_reg == IDLE);
  assign a_o             = a_reg;
  assign rising_edge_o   = rise_reg;
  assign falling_edge_o  = fall_reg;
  assign busy_o          = busy_reg;
  assign done_o          = done_reg;

endmodule
